// File: rtl/dmem_pkg.sv
// dmem_pkg: shared states, request kinds and funct3 size codes for the data-memory responder.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic [1:0] {REQ_NONE, REQ_LD, REQ_ST, REQ_ILL} req_t;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    function automatic logic f3_legal(input logic [2:0] f3);
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane alignment for loads and stores (mask, merged store word, extended load word, misalign flag).
module lsu_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_raw,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword,
    output logic [31:0] o_rword,
    output logic        o_misalign
);
    logic        w_byte, w_half;
    logic [31:0] w_shift, w_rep;
    always_comb begin
        w_byte     = i_funct3[1:0] == 2'b00;
        w_half     = i_funct3[1:0] == 2'b01;
        w_shift    = i_raw >> {i_lane, 3'b000};
        o_be       = w_byte ? 4'b0001 << i_lane : w_half ? 4'b0011 << {i_lane[1], 1'b0} : 4'b1111;
        w_rep      = w_byte ? {4{i_wdata[7:0]}} : w_half ? {2{i_wdata[15:0]}} : i_wdata;
        o_wword    = i_raw;
        for (int k = 0; k < 4; k++)
            if (o_be[k]) o_wword[8*k +: 8] = w_rep[8*k +: 8];
        // funct3[2] selects zero extension (BU/HU)
        o_rword    = w_byte ? {{24{~i_funct3[2] & w_shift[7]}}, w_shift[7:0]}
                   : w_half ? {{16{~i_funct3[2] & w_shift[15]}}, w_shift[15:0]} : i_raw;
        o_misalign = w_half ? i_lane[0] : i_funct3[1:0] == 2'b10 ? |i_lane : 1'b0;
    end
endmodule

// File: rtl/dmem_wait_responder.sv
// dmem_wait_responder: load/store data memory with configurable wait states, pipeline stall and access checking.
module dmem_wait_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  w_en,
    input  logic                  read_en,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  resp_valid,
    output logic                  err,
    output logic                  stall
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);
    state_t                r_state, w_next;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata;
    logic [2:0]            r_f3, w_f3;
    req_t                  r_req, w_req, w_req_in;
    logic [31:0]           r_mem [DEPTH_WORDS];
    logic [31:0]           w_raw, w_wword, w_rword;
    logic [3:0]            w_be;
    logic                  w_idle, w_mis, w_err, w_go;

    assign w_req_in = w_en && read_en ? REQ_ILL : w_en ? REQ_ST : read_en ? REQ_LD : REQ_NONE;
    assign w_idle   = r_state == IDLE;
    // With zero wait states the access completes straight from IDLE, so use the live inputs there
    assign w_addr   = w_idle ? addr : r_addr;
    assign w_wdata  = w_idle ? data_in : r_wdata;
    assign w_f3     = w_idle ? funct3 : r_f3;
    assign w_req    = w_idle ? w_req_in : r_req;
    assign w_raw    = r_mem[w_addr[IW+1:2]];
    assign w_err    = w_req == REQ_ILL || w_mis || |(w_addr >> (IW + 2)) || !f3_legal(w_f3);
    assign w_go     = w_next == RESP;
    assign stall    = (w_idle && w_req_in != REQ_NONE) || r_state == BUSY;

    lsu_align u_align (
        .i_lane     (w_addr[1:0]),
        .i_funct3   (w_f3),
        .i_raw      (w_raw),
        .i_wdata    (w_wdata),
        .o_be       (w_be),
        .o_wword    (w_wword),
        .o_rword    (w_rword),
        .o_misalign (w_mis)
    );

    always_comb begin
        w_next = IDLE;
        if (w_idle) w_next = w_req_in != REQ_NONE ? (WS == 4'd0 ? RESP : BUSY) : IDLE;
        else if (r_state == BUSY) w_next = r_cnt == 4'd1 ? RESP : BUSY;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_f3       <= '0;
            r_req      <= REQ_NONE;
            data_out   <= '0;
            resp_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_idle ? WS : r_state == BUSY ? r_cnt - 4'd1 : r_cnt;
            if (w_idle) begin
                r_addr  <= addr;
                r_wdata <= data_in;
                r_f3    <= funct3;
                r_req   <= w_req_in;
            end
            resp_valid <= w_go;
            err        <= w_go && w_err;
            data_out   <= w_go && !w_err && w_req == REQ_LD ? w_rword : '0;
        end
    end

    always_ff @(posedge clk)
        if (!reset && w_go && !w_err && w_req == REQ_ST && |w_be) r_mem[w_addr[IW+1:2]] <= w_wword;
endmodule

// File: tb/tb_dmem_wait_responder.sv
// tb_dmem_wait_responder: scoreboard bench driving a 2-wait-state and a 0-wait-state responder.
module tb_dmem_wait_responder;
    import dmem_pkg::*;
    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_v  [2];
    logic [31:0] addr_v [2];
    logic [31:0] din_v  [2];
    logic        wen_v  [2];
    logic        ren_v  [2];
    logic [2:0]  f3_v   [2];
    logic [31:0] dout_v [2];
    logic        rv_v   [2];
    logic        err_v  [2];
    logic        st_v   [2];
    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dmem_wait_responder #(.WAIT_STATES(2)) u_ws2 (
        .clk(clk), .reset(rst_v[0]), .addr(addr_v[0]), .data_in(din_v[0]), .w_en(wen_v[0]),
        .read_en(ren_v[0]), .funct3(f3_v[0]), .data_out(dout_v[0]), .resp_valid(rv_v[0]),
        .err(err_v[0]), .stall(st_v[0])
    );
    dmem_wait_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(rst_v[1]), .addr(addr_v[1]), .data_in(din_v[1]), .w_en(wen_v[1]),
        .read_en(ren_v[1]), .funct3(f3_v[1]), .data_out(dout_v[1]), .resp_valid(rv_v[1]),
        .err(err_v[1]), .stall(st_v[1])
    );

    task automatic access(input string nm, input int u, input logic we, input logic re,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] ed, input logic ee);
        int   stalls = 0;
        int   cyc = 0;
        int   ws = (u == 0) ? 2 : 0;
        exp_t e;
        sbq.push_back('{ed, ee});
        @(negedge clk);
        wen_v[u] = we; ren_v[u] = re; f3_v[u] = f3; addr_v[u] = a; din_v[u] = d;
        #1;
        while (!rv_v[u] && cyc < 40) begin
            stalls += int'(st_v[u]);
            cyc++;
            @(negedge clk);
            #1;
        end
        e = sbq.pop_front();
        checks++;
        if (rv_v[u] !== 1'b1) begin
            errors++;
            $display("FAIL %s u%0d timeout: no resp_valid after %0d cycles", nm, u, cyc);
        end else begin
            checks += 5;
            if (cyc !== ws + 1) begin errors++; $display("FAIL %s u%0d latency: got %0d expected %0d", nm, u, cyc, ws + 1); end
            if (stalls !== ws + 1) begin errors++; $display("FAIL %s u%0d stall_cycles: got %0d expected %0d", nm, u, stalls, ws + 1); end
            if (st_v[u] !== 1'b0) begin errors++; $display("FAIL %s u%0d stall_in_resp: got %b expected 0", nm, u, st_v[u]); end
            if (dout_v[u] !== e.data) begin errors++; $display("FAIL %s u%0d data_out: got %h expected %h", nm, u, dout_v[u], e.data); end
            if (err_v[u] !== e.err) begin errors++; $display("FAIL %s u%0d err: got %b expected %b", nm, u, err_v[u], e.err); end
        end
        @(negedge clk);
        wen_v[u] = 1'b0; ren_v[u] = 1'b0;
        #1;
        checks++;
        if (rv_v[u] !== 1'b0 || dout_v[u] !== 32'h0 || err_v[u] !== 1'b0) begin
            errors++;
            $display("FAIL %s u%0d after_resp: rv=%b err=%b data=%h expected 0 0 0", nm, u, rv_v[u], err_v[u], dout_v[u]);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_v[0] = 1'b1; rst_v[1] = 1'b1;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (dout_v[u] !== 32'h0 || rv_v[u] !== 1'b0 || err_v[u] !== 1'b0 || st_v[u] !== 1'b0) begin
                errors++;
                $display("FAIL reset u%0d: data=%h rv=%b err=%b stall=%b expected all 0", u, dout_v[u], rv_v[u], err_v[u], st_v[u]);
            end
        end
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    endtask

    task automatic test_word();
        access("sw_10", 0, 1, 0, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        access("lw_10", 0, 0, 1, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    endtask

    task automatic test_byte();
        access("sw_20", 0, 1, 0, F3_W, 32'h20, 32'h0, 32'h0, 0);
        access("sb_21", 0, 1, 0, F3_B, 32'h21, 32'h12345681, 32'h0, 0);
        access("lb_21", 0, 0, 1, F3_B, 32'h21, 32'h0, 32'hFFFFFF81, 0);
        access("lbu_21", 0, 0, 1, F3_BU, 32'h21, 32'h0, 32'h00000081, 0);
        access("lw_20", 0, 0, 1, F3_W, 32'h20, 32'h0, 32'h00008100, 0);
    endtask

    task automatic test_misalign();
        access("lw_22", 0, 0, 1, F3_W, 32'h22, 32'h0, 32'h0, 1);
        access("lh_23", 0, 0, 1, F3_H, 32'h23, 32'h0, 32'h0, 1);
        access("sh_23", 0, 1, 0, F3_H, 32'h23, 32'hFFFFFFFF, 32'h0, 1);
        access("f3_011", 0, 0, 1, 3'b011, 32'h20, 32'h0, 32'h0, 1);
        access("f3_110", 0, 0, 1, 3'b110, 32'h20, 32'h0, 32'h0, 1);
        access("lw_20_again", 0, 0, 1, F3_W, 32'h20, 32'h0, 32'h00008100, 0);
    endtask

    task automatic test_zero_wait();
        access("sh_42", 1, 1, 0, F3_H, 32'h42, 32'h1234BEEF, 32'h0, 0);
        access("lhu_42", 1, 0, 1, F3_HU, 32'h42, 32'h0, 32'h0000BEEF, 0);
        access("lh_42", 1, 0, 1, F3_H, 32'h42, 32'h0, 32'hFFFFBEEF, 0);
        access("lb_43", 1, 0, 1, F3_B, 32'h43, 32'h0, 32'hFFFFFFBE, 0);
    endtask

    task automatic test_reset_busy();
        access("sw_30", 0, 1, 0, F3_W, 32'h30, 32'hCAFEF00D, 32'h0, 0);
        @(negedge clk);
        wen_v[0] = 1'b1; ren_v[0] = 1'b0; f3_v[0] = F3_W; addr_v[0] = 32'h30; din_v[0] = 32'h12345678;
        @(negedge clk);
        #1;
        checks++;
        if (st_v[0] !== 1'b1) begin errors++; $display("FAIL busy_stall: got %b expected 1", st_v[0]); end
        rst_v[0] = 1'b1; wen_v[0] = 1'b0;
        #1;
        checks++;
        if (st_v[0] !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", st_v[0]); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rv_v[0] !== 1'b0) begin errors++; $display("FAIL reset_no_resp: got %b expected 0", rv_v[0]); end
        end
        rst_v[0] = 1'b0;
        access("lw_30", 0, 0, 1, F3_W, 32'h30, 32'h0, 32'hCAFEF00D, 0);
    endtask

    task automatic test_illegal();
        access("sw_0", 0, 1, 0, F3_W, 32'h0, 32'h11223344, 32'h0, 0);
        access("dual", 0, 1, 1, F3_W, 32'h0, 32'h55555555, 32'h0, 1);
        access("sw_oor", 0, 1, 0, F3_W, 32'h0001_0000, 32'hAAAAAAAA, 32'h0, 1);
        access("lw_oor", 0, 0, 1, F3_W, 32'h0001_0000, 32'h0, 32'h0, 1);
        access("lw_0", 0, 0, 1, F3_W, 32'h0, 32'h0, 32'h11223344, 0);
    endtask

    task automatic test_back_to_back();
        access("b2b_sw", 1, 1, 0, F3_W, 32'h50, 32'h0BADF00D, 32'h0, 0);
        access("b2b_lw", 1, 0, 1, F3_W, 32'h50, 32'h0, 32'h0BADF00D, 0);
        access("b2b_lbu", 1, 0, 1, F3_BU, 32'h53, 32'h0, 32'h0000000B, 0);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_v[u] = 1'b0; addr_v[u] = '0; din_v[u] = '0; wen_v[u] = 1'b0; ren_v[u] = 1'b0; f3_v[u] = '0;
        end
        test_reset();
        test_word();
        test_byte();
        test_misalign();
        test_zero_wait();
        test_reset_busy();
        test_illegal();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
